ff_apb_ctrl: RTL and testbench
==============================

# ff_apb_ctrl

APB slave controller inside `flunkyfive`, directly downstream of the APB master that drives the DUT. It decodes the 16-bit APB address space into a small control/status register bank and a memory window into core instruction/data RAM. It gives the bench (or host) run/step/halt control and a 64-bit cycle counter. It is a zero-wait-state (APB2, no `pready`) slave; every transfer completes in one setup plus one access cycle.

## Interface
- `MEM_AW`, 13: word-address width of the memory window; must be ≤13.
- `ID_VALUE`, 32'h4646_3546: constant returned by the ID register.
- `clk` in 1: single clock; every flop uses the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `paddr` in 16: APB address; byte address, `paddr[1:0]` ignored.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `pwdata` in 32: APB write data.
- `prdata` out 32: APB read data.
- `core_run` out 1: core enable level.
- `core_step` out 1: single-cycle pulse; core executes one instruction.
- `core_halted` in 1: core has halted (level).
- `core_pc` in 32: current core PC.
- `mem_addr` out MEM_AW: RAM word address, `paddr[MEM_AW+1:2]`.
- `mem_wdata` out 32: RAM write data, `pwdata`.
- `mem_we`, `mem_re` out 1: RAM write/read strobes.
- `mem_rdata` in 32: synchronous RAM read data, valid one cycle after `mem_re`.

## Operation
- Phases: setup = `psel & ~penable`, access = `psel & penable`. Register writes commit on the access-phase edge.
- Register map; unmapped addresses below 0x8000 read 0, ignore writes, set ERR:
  - 0x0000 ID: read-only, `ID_VALUE`.
  - 0x0004 CTRL: bit0 RUN (RW). bit1 STEP: write 1 gives a one-cycle `core_step` pulse; reads 0. bit2 CLR_CNT: write 1 zeroes the cycle counter; reads 0.
  - 0x0008 STATUS: bit0 RUN, bit1 `core_halted`, bit2 ERR. ERR is sticky and write-1-to-clear.
  - 0x000C PC: read-only `core_pc`, sampled in the setup phase.
  - 0x0010 CYCLE_LO: reading it returns count[31:0] and loads count[63:32] into a shadow.
  - 0x0014 CYCLE_HI: returns the shadow.
  - 0x0018 SCRATCH: RW, 32 bits.
  - 0x8000–0xFFFF: memory window.
- Cycle counter: 64 bits; +1 on every clock where RUN=1; wraps from 2^64−1 to 0. If CLR_CNT and an increment coincide, the result is 0.
- Halt: a rising edge of `core_halted` clears RUN. An APB write of RUN=1 in the same cycle wins.
- STEP while RUN=1 is ignored. No pulse is generated.
- Memory window, RUN=0:
  - Setup phase with `pwrite=0`: `mem_re`=1 for that cycle.
  - Access phase with `pwrite=1`: `mem_we`=1 for that cycle.
- Memory window, RUN=1: no strobe is issued, reads return 0, and ERR is set.
- Reset mid-transfer: all state goes to reset values and the transfer is abandoned with no RAM write.

## Timing
- Reset values: `prdata`=0, `core_run`=0, `core_step`=0, `mem_we`=0, `mem_re`=0, counter=0, shadow=0, SCRATCH=0, ERR=0.
- `prdata` is registered and loaded on the setup-phase edge for register reads, so it is valid for the whole access phase.
- For window reads, `prdata` selects `mem_rdata` during the access phase, using a registered window-hit flag.
- `prdata` returns to 0 after the access phase.
- `mem_re`, `mem_we`, `mem_addr` and `mem_wdata` are combinational from the APB inputs and RUN.
- `core_run` updates on the access-phase edge of the CTRL write.
- `core_step` is high exactly one cycle, starting the cycle after the access edge.
- CLR_CNT takes effect at the access edge.
- STATUS.ERR sets at the access edge of the offending transfer.
- Back-to-back transfers (setup immediately after access) are supported with no idle cycle.

## Test plan
- Reset and ID: reset, then read 0x0000 → 0x46463546. Read 0x0018 → 0. Read 0x0008 → 0.
- Memory window:
  - With RUN=0, write 0xCAFEF00D to 0x8010 → `mem_we` pulses for one cycle with `mem_addr`=4.
  - Read back 0x8010 → `prdata`=0xCAFEF00D in the access phase.
- Run, halt and counter:
  - Write CTRL=1, idle 10 cycles, assert `core_halted` → RUN clears and the counter freezes.
  - Read CYCLE_LO → 11 (±1 for the write edge, checked against the model). Read CYCLE_HI → 0.
- Wrap and clear:
  - Force the counter to 0xFFFF_FFFF_FFFF_FFFE, run 2 cycles → 0.
  - Write CLR_CNT during RUN → next read is ≤2.
- Step and error:
  - STEP with RUN=0 → exactly one `core_step` pulse.
  - STEP with RUN=1 → no pulse.
  - Window write during RUN → no `mem_we`, STATUS=0x5. Write 0x4 to STATUS → ERR clears.
- Reset mid-write: deassert `resetn` between setup and access of a window write → no `mem_we`, and all outputs are at reset values.

Source files
------------

// File: rtl/ff_apb_ctrl.sv
// APB2 zero-wait-state slave for flunkyfive: control/status registers, a 64-bit
// cycle counter with read shadow, and a memory window onto core RAM.
module ff_apb_ctrl #(
  parameter int unsigned MEM_AW   = 13,
  parameter logic [31:0] ID_VALUE = 32'h4646_3546
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              core_run,
  output logic              core_step,
  input  logic              core_halted,
  input  logic [31:0]       core_pc,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_PC      = 3'd3;
  localparam logic [2:0] REG_CYC_LO  = 3'd4;
  localparam logic [2:0] REG_CYC_HI  = 3'd5;
  localparam logic [2:0] REG_SCRATCH = 3'd6;

  logic [31:0] prdata_q, prdata_d;
  logic        win_rd_q, win_rd_d;
  logic        setup_q, setup_d;
  logic        run_q, run_d;
  logic        step_q, step_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;

  logic        setup_ph;
  logic        access_ph;
  logic        win_hit;
  logic        reg_hit;
  logic [2:0]  reg_sel;
  logic        halt_rise;
  logic [31:0] reg_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^paddr[1:0];

  // An access phase only counts if this slave saw its setup phase; this is
  // what drops a transfer whose setup was cut off by reset.
  assign setup_ph  = psel & ~penable;
  assign access_ph = psel & penable & setup_q;
  assign win_hit   = paddr[15];
  assign reg_sel   = paddr[4:2];
  assign reg_hit   = ~paddr[15] & (paddr[14:5] == 10'd0) & (reg_sel != 3'd7);
  assign halt_rise = core_halted & ~halted_q;

  assign mem_addr  = paddr[MEM_AW+1:2];
  assign mem_wdata = pwdata;
  assign mem_re    = setup_ph & ~pwrite & win_hit & ~run_q;
  assign mem_we    = access_ph & pwrite & win_hit & ~run_q;

  assign prdata    = win_rd_q ? mem_rdata : prdata_q;
  assign core_run  = run_q;
  assign core_step = step_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_ID:      reg_rdata = ID_VALUE;
      REG_CTRL:    reg_rdata = {31'd0, run_q};
      REG_STATUS:  reg_rdata = {29'd0, err_q, core_halted, run_q};
      REG_PC:      reg_rdata = core_pc;
      REG_CYC_LO:  reg_rdata = cnt_q[31:0];
      REG_CYC_HI:  reg_rdata = shadow_q;
      REG_SCRATCH: reg_rdata = scratch_q;
      default:     reg_rdata = '0;
    endcase
  end

  always_comb begin
    prdata_d  = '0;
    win_rd_d  = 1'b0;
    setup_d   = setup_ph;
    halted_d  = core_halted;
    step_d    = 1'b0;
    err_d     = err_q;
    shadow_d  = shadow_q;
    scratch_d = scratch_q;
    cnt_d     = run_q ? cnt_q + 64'd1 : cnt_q;
    run_d     = halt_rise ? 1'b0 : run_q;

    // Read data is captured at the setup edge so it holds for the access phase.
    if (setup_ph && !pwrite) begin
      if (reg_hit) begin
        prdata_d = reg_rdata;
        if (reg_sel == REG_CYC_LO) shadow_d = cnt_q[63:32];
      end else if (win_hit && !run_q) begin
        win_rd_d = 1'b1;
      end
    end

    if (access_ph) begin
      if (pwrite && reg_hit) begin
        case (reg_sel)
          REG_CTRL: begin
            run_d = pwdata[0];
            if (pwdata[1] && !run_q) step_d = 1'b1;
            if (pwdata[2]) cnt_d = '0;
          end
          REG_STATUS:  if (pwdata[2]) err_d = 1'b0;
          REG_SCRATCH: scratch_d = pwdata;
          default: ;
        endcase
      end
      if ((!win_hit && !reg_hit) || (win_hit && run_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prdata_q  <= '0;
      win_rd_q  <= 1'b0;
      setup_q   <= 1'b0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      scratch_q <= '0;
    end else begin
      prdata_q  <= prdata_d;
      win_rd_q  <= win_rd_d;
      setup_q   <= setup_d;
      run_q     <= run_d;
      step_q    <= step_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
    end
  end

endmodule

// File: tb/tb_ff_apb_ctrl.sv
// Directed bench for ff_apb_ctrl: APB master tasks, behavioural RAM, and a
// scoreboard queue of expected read data.
module tb_ff_apb_ctrl;

  localparam int MEM_AW = 13;

  logic              clk;
  logic              resetn;
  logic [15:0]       paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              core_run;
  logic              core_step;
  logic              core_halted;
  logic [31:0]       core_pc;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0]       ram [0:(1<<MEM_AW)-1];
  int                we_cnt = 0;
  int                step_cnt = 0;
  logic [MEM_AW-1:0] we_addr = '0;

  ff_apb_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .resetn(resetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .core_run(core_run),
    .core_step(core_step), .core_halted(core_halted), .core_pc(core_pc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Clock and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
      we_addr       <= mem_addr;
    end
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (core_step) step_cnt <= step_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); d = prdata;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    apb_read(a, got);
    chk(tag, got, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    int w0, s0;
    resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; core_halted = 1'b0; core_pc = 32'h0000_1000;
    mem_rdata = '0;
    for (int i = 0; i < (1 << MEM_AW); i++) ram[i] = '0;

    #3;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_run", {31'd0, core_run}, 32'h0);
    chk("rst_step", {31'd0, core_step}, 32'h0);
    chk("rst_we", {31'd0, mem_we}, 32'h0);
    chk("rst_re", {31'd0, mem_re}, 32'h0);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    idle(1);

    rd_chk("id", 16'h0000, 32'h4646_3546);
    chk("prdata_idle", prdata, 32'h0);
    rd_chk("scratch_rst", 16'h0018, 32'h0);
    rd_chk("status_rst", 16'h0008, 32'h0);

    v = $urandom;
    apb_write(16'h0018, v);
    rd_chk("scratch_rw", 16'h0018, v);
    core_pc = $urandom;
    rd_chk("pc", 16'h000C, core_pc);

    // Memory window with RUN=0
    w0 = we_cnt;
    apb_write(16'h8010, 32'hCAFE_F00D);
    idle(1);
    chk("win_we_pulses", we_cnt - w0, 1);
    chk("win_we_addr", {19'd0, we_addr}, 32'd4);
    rd_chk("win_rd", 16'h8010, 32'hCAFE_F00D);
    v = $urandom;
    apb_write(16'h9FFC, v);
    rd_chk("win_rd_top", 16'h9FFC, v);

    // Run, halt on rising core_halted, counter freezes
    apb_write(16'h0004, 32'h1);
    chk("run_set", {31'd0, core_run}, 32'h1);
    repeat (10) @(posedge clk);
    #1 core_halted = 1'b1;
    idle(1);
    chk("run_halted", {31'd0, core_run}, 32'h0);
    rd_chk("status_halt", 16'h0008, 32'h2);
    rd_chk("cyc_lo", 16'h0010, 32'd11);
    rd_chk("cyc_hi", 16'h0014, 32'd0);
    rd_chk("cyc_frozen", 16'h0010, 32'd11);

    // Wrap from 2^64-2
    core_halted = 1'b0;
    idle(2);
    @(negedge clk) force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clk);
    @(negedge clk) release dut.cnt_q;
    idle(1);
    rd_chk("cyc_lo_pre", 16'h0010, 32'hFFFF_FFFE);
    rd_chk("cyc_hi_pre", 16'h0014, 32'hFFFF_FFFF);
    apb_write(16'h0004, 32'h1);
    @(posedge clk);
    #1 core_halted = 1'b1;
    idle(1);
    rd_chk("cyc_lo_wrap", 16'h0010, 32'h0);
    rd_chk("cyc_hi_wrap", 16'h0014, 32'h0);

    // Clear while running
    core_halted = 1'b0;
    idle(2);
    apb_write(16'h0004, 32'h1);
    idle(5);
    apb_write(16'h0004, 32'h5);
    apb_read(16'h0010, v);
    checks++;
    assert (v <= 32'd2) else begin
      errors++;
      $error("FAIL cyc_clr: observed %h expected <= 2", v);
    end
    chk("run_after_clr", {31'd0, core_run}, 32'h1);

    // STEP ignored while running; window blocked while running
    s0 = step_cnt;
    apb_write(16'h0004, 32'h3);
    idle(3);
    chk("step_run_ignored", step_cnt - s0, 0);
    w0 = we_cnt;
    apb_write(16'h8020, 32'h1234_5678);
    idle(1);
    chk("win_run_no_we", we_cnt - w0, 0);
    rd_chk("status_err", 16'h0008, 32'h5);
    apb_write(16'h0008, 32'h4);
    rd_chk("status_clr", 16'h0008, 32'h1);
    rd_chk("win_run_rd", 16'h8010, 32'h0);
    rd_chk("status_err_rd", 16'h0008, 32'h5);
    apb_write(16'h0008, 32'h4);

    // STEP with RUN=0
    apb_write(16'h0004, 32'h0);
    s0 = step_cnt;
    apb_write(16'h0004, 32'h2);
    chk("step_hi", {31'd0, core_step}, 32'h1);
    idle(1);
    chk("step_lo", {31'd0, core_step}, 32'h0);
    idle(2);
    chk("step_count", step_cnt - s0, 1);
    chk("step_no_run", {31'd0, core_run}, 32'h0);

    // Unmapped register address
    rd_chk("unmapped_rd", 16'h0040, 32'h0);
    rd_chk("status_unmapped", 16'h0008, 32'h4);
    apb_write(16'h0008, 32'h4);
    rd_chk("status_clr2", 16'h0008, 32'h0);

    // Reset between setup and access of a window write
    apb_write(16'h0018, 32'hA5A5_5A5A);
    apb_write(16'h7000, 32'h0);
    w0 = we_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h8020; pwdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 resetn = 1'b0;
    #2;
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_run", {31'd0, core_run}, 32'h0);
    chk("mid_rst_step", {31'd0, core_step}, 32'h0);
    chk("mid_rst_re", {31'd0, mem_re}, 32'h0);
    penable = 1'b1;
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", {31'd0, mem_we}, 32'h0);
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    idle(1);
    chk("mid_rst_we_cnt", we_cnt - w0, 0);
    chk("mid_rst_ram", ram[8], 32'h0);
    rd_chk("mid_rst_scratch", 16'h0018, 32'h0);
    rd_chk("mid_rst_status", 16'h0008, 32'h0);
    rd_chk("mid_rst_cyc", 16'h0010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
